// File: rtl/chgcap_pkg.sv
// Shared types and constants for the change_capture value-change recorder.
package chgcap_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DROP_W = 8;

   function automatic int entry_w(input int ts_w, input int width);
      return ts_w + width;
   endfunction

endpackage

// File: rtl/chgcap_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero when empty.
module chgcap_fifo
   import chgcap_pkg::*;
#(
   parameter int DW    = 24,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [LW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == LW'(DEPTH));
   assign level   = cnt_q;
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a write when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem_q[rp_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + AW'(1);
         if (do_pop)  rp_q <= rp_q + AW'(1);
         cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wp_q] <= wdata;
   end

endmodule

// File: rtl/change_capture.sv
// Value-change recorder: logs {timestamp, value} on every change of sig_in.
// Optional CHANGE_CAPTURE_MASK_EN adds trig_mask to select triggering bits.
module change_capture
   import chgcap_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int TS_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         sig_in,
`ifdef CHANGE_CAPTURE_MASK_EN
   input  logic [WIDTH-1:0]         trig_mask,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_value,
   output logic [TS_W-1:0]          out_time,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int EW = entry_w(TS_W, WIDTH);

   state_e             state_q, state_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic               ovf_q, ovf_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               push, pop, full, empty, trig;
   logic [TS_W-1:0]    ts_rec;
   logic [EW-1:0]      wdata, rdata;

`ifdef CHANGE_CAPTURE_MASK_EN
   assign trig = |((sig_in ^ prev_q) & trig_mask);
`else
   assign trig = |(sig_in ^ prev_q);
`endif

   always_comb begin
      state_d = state_q;
      ts_d    = ts_q;
      prev_d  = prev_q;
      push    = 1'b0;
      ts_rec  = ts_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               // Initial-value dump always lands at time zero
               push    = 1'b1;
               ts_rec  = '0;
               prev_d  = sig_in;
               ts_d    = TS_W'(1);
               state_d = RUN;
            end
         end
         RUN: begin
            if (en) begin
               push   = trig;
               prev_d = sig_in;
               ts_d   = ts_q + TS_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop   = out_valid && out_ready;
   assign wdata = {ts_rec, sig_in};

   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (clear) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end else if (push && full && !pop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ts_q    <= '0;
         prev_q  <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         ts_q    <= ts_d;
         prev_q  <= prev_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   chgcap_fifo #(
      .DW    (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign out_valid = !empty;
   assign out_value = rdata[WIDTH-1:0];
   assign out_time  = rdata[EW-1 -: TS_W];
   assign overflow  = ovf_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_change_capture.sv
// Directed self-checking bench for change_capture (wide and 4-bit timestamp).
module tb_change_capture;

   logic       clk, rst_n, en, clear, out_ready;
   logic [7:0] sig_in;
`ifdef CHANGE_CAPTURE_MASK_EN
   logic [7:0] trig_mask;
`endif

   logic        v_a, ovf_a, v_b, ovf_b;
   logic [7:0]  val_a, drop_a, val_b, drop_b;
   logic [15:0] time_a;
   logic [3:0]  time_b;
   logic [4:0]  lvl_a, lvl_b;

   int checks = 0;
   int errors = 0;

   change_capture #(.WIDTH(8), .DEPTH(16), .TS_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clear     (clear),
      .sig_in    (sig_in),
`ifdef CHANGE_CAPTURE_MASK_EN
      .trig_mask (trig_mask),
`endif
      .out_valid (v_a),
      .out_ready (out_ready),
      .out_value (val_a),
      .out_time  (time_a),
      .overflow  (ovf_a),
      .drop_cnt  (drop_a),
      .level     (lvl_a)
   );

   change_capture #(.WIDTH(8), .DEPTH(16), .TS_W(4)) dut_w (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clear     (clear),
      .sig_in    (sig_in),
`ifdef CHANGE_CAPTURE_MASK_EN
      .trig_mask (trig_mask),
`endif
      .out_valid (v_b),
      .out_ready (out_ready),
      .out_value (val_b),
      .out_time  (time_b),
      .overflow  (ovf_b),
      .drop_cnt  (drop_b),
      .level     (lvl_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0;
      sig_in = 8'h00; out_ready = 1'b0;
`ifdef CHANGE_CAPTURE_MASK_EN
      trig_mask = 8'hFF;
`endif
      #1;
      chk("rst_valid", 32'(v_a), 0);
      chk("rst_level", 32'(lvl_a), 0);
      chk("rst_value", 32'(val_a), 0);
      chk("rst_time", 32'(time_a), 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      chk("rst_drop", 32'(drop_a), 0);
      #11 rst_n = 1'b1;
      tick();

      // Initial dump
      sig_in = 8'hA5; en = 1'b1;
      tick();
      chk("dump_valid", 32'(v_a), 1);
      chk("dump_value", 32'(val_a), 'hA5);
      chk("dump_time", 32'(time_a), 0);
      chk("dump_level", 32'(lvl_a), 1);
      repeat (3) tick();
      chk("dump_hold_level", 32'(lvl_a), 1);

      // Changes at time 4 and 9
      sig_in = 8'h3C;
      tick();
      chk("chg1_level", 32'(lvl_a), 2);
      repeat (4) tick();
      sig_in = 8'hFF;
      tick();
      chk("chg2_level", 32'(lvl_a), 3);
      chk("hold_value", 32'(val_a), 'hA5);
      out_ready = 1'b1;
      tick();
      chk("rd1_value", 32'(val_a), 'h3C);
      chk("rd1_time", 32'(time_a), 4);
      tick();
      chk("rd2_value", 32'(val_a), 'hFF);
      chk("rd2_time", 32'(time_a), 9);
      tick();
      chk("rd_empty_valid", 32'(v_a), 0);
      chk("rd_empty_value", 32'(val_a), 0);
      chk("rd_empty_time", 32'(time_a), 0);
      out_ready = 1'b0;

      // Overflow: dump plus 20 toggles into 16 slots
      do_reset();
      sig_in = 8'h00; en = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         sig_in = ~sig_in;
         tick();
      end
      chk("ovf_level", 32'(lvl_a), 16);
      chk("ovf_flag", 32'(ovf_a), 1);
      chk("ovf_drop", 32'(drop_a), 5);

      // Full with simultaneous push and pop
      sig_in = ~sig_in; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fpp_level", 32'(lvl_a), 16);
      chk("fpp_drop", 32'(drop_a), 5);
      chk("fpp_head_value", 32'(val_a), 'hFF);
      chk("fpp_head_time", 32'(time_a), 1);
      out_ready = 1'b1;
      repeat (15) tick();
      out_ready = 1'b0;
      chk("fpp_tail_level", 32'(lvl_a), 1);
      chk("fpp_tail_value", 32'(val_a), 'hFF);
      chk("fpp_tail_time", 32'(time_a), 21);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_level", 32'(lvl_a), 0);
      chk("clr_ovf", 32'(ovf_a), 0);
      chk("clr_drop", 32'(drop_a), 0);
      chk("clr_valid", 32'(v_a), 0);

      // Timestamp wrap on the 4-bit instance and enable gap
      do_reset();
      sig_in = 8'h00; en = 1'b1;
      tick();
      repeat (16) tick();
      sig_in = 8'h11;
      tick();
      chk("wrap_level", 32'(lvl_b), 2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("wrap_time_w", 32'(time_b), 1);
      chk("wrap_value_w", 32'(val_b), 'h11);
      chk("wrap_time_wide", 32'(time_a), 17);
      en = 1'b0;
      tick();
      sig_in = 8'h22; tick();
      sig_in = 8'h33; tick();
      sig_in = 8'h44; tick();
      chk("gap_level", 32'(lvl_b), 1);
      en = 1'b1;
      tick();
      chk("reen_level", 32'(lvl_b), 2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("reen_time", 32'(time_b), 0);
      chk("reen_value", 32'(val_b), 'h44);
      chk("reen_time_wide", 32'(time_a), 0);

`ifdef CHANGE_CAPTURE_MASK_EN
      do_reset();
      trig_mask = 8'h0F; sig_in = 8'h00; en = 1'b1;
      tick();
      sig_in = 8'hF0;
      tick();
      chk("mask_blocked", 32'(lvl_a), 1);
      sig_in = 8'hF1;
      tick();
      chk("mask_hit", 32'(lvl_a), 2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("mask_value", 32'(val_a), 'hF1);
      rst_n = 1'b0;
      #1;
      chk("mask_rst_valid", 32'(v_a), 0);
      chk("mask_rst_level", 32'(lvl_a), 0);
      rst_n = 1'b1;
`endif

      // Asynchronous reset mid-stream clears immediately
      do_reset();
      sig_in = 8'h5A; en = 1'b1;
      tick();
      chk("mid_pre_valid", 32'(v_a), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(v_a), 0);
      chk("mid_rst_level", 32'(lvl_a), 0);
      chk("mid_rst_value", 32'(val_a), 0);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
